tdm_multiplexer: RTL and testbench

Four-channel, round-robin time-division multiplexer that merges four independent input streams onto one shared data line tagged with a 2-bit channel selector. It is the transmit end of the selector/demultiplexer path: its `f`/`selector` outputs feed a 1-to-4 demultiplexer, which routes `f` to output a/b/c/d by `selector`. The block adds valid/ready flow control, fair arbitration and one registered output stage.

---
 rtl/tdm_multiplexer_pkg.sv | 13 +
 rtl/tdm_multiplexer_rr_arbiter4.sv | 38 +++
 rtl/tdm_multiplexer.sv | 70 +++++++
 tb/tb_tdm_multiplexer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_multiplexer_pkg.sv
// Purpose : shared channel-count and selector definitions for the TDM mux/demux pair.
// Latency : n/a (declarations only).
// Backpres: n/a.
//
// Contents: N_CH (number of TDM channels), SEL_W (selector width), sel_t.
package tdm_pkg;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/tdm_multiplexer_rr_arbiter4.sv
// Purpose : four-way round-robin arbiter, priority starts at ptr and wraps.
// Latency : purely combinational, zero cycles.
// Backpres: none; the caller qualifies grant with its own load enable.
//
// Ports:
//   req[3:0]   requesting channels
//   ptr        highest-priority channel this cycle
//   grant[3:0] one-hot grant, zero when no request
//   grant_idx  encoded grant (0 when no request)
module rr_arbiter4
   import tdm_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  grant,
   output logic [SEL_W-1:0] grant_idx
);

   sel_t idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int off = 0; off < N_CH; off++) begin
         // 2-bit addition wraps modulo 4, giving the ptr, ptr+1, ... order.
         idx = ptr + sel_t'(off);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tdm_multiplexer.sv
// Purpose : merge four valid/ready streams round-robin onto one tagged output word.
// Latency : one cycle; a word accepted at edge N appears on f/selector after edge N.
// Backpres: output register stalls while out_valid && !out_ready; all in_ready drop.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_data[4*W-1:0] channel i at [i*WIDTH +: WIDTH]
//   in_valid[3:0]    per-channel word present
//   in_ready[3:0]    per-channel accept (combinational, at most one high)
//   f, selector      registered output word and its source channel
//   out_valid        output register holds a word
//   out_ready        downstream accepts the word
module tdm_multiplexer
   import tdm_pkg::*;
#(
   parameter int WIDTH = 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*WIDTH-1:0]    in_data,
   input  logic [3:0]            in_valid,
   output logic [3:0]            in_ready,
   output logic [WIDTH-1:0]      f,
   output logic [SEL_W-1:0]      selector,
   output logic                  out_valid,
   input  logic                  out_ready
);

   sel_t             ptr;
   logic [N_CH-1:0]  grant;
   sel_t             grant_idx;
   logic             load_en;
   logic             in_xfer;
   logic [WIDTH-1:0] sel_data;

   rr_arbiter4 u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // The output register can be refilled when empty or being drained this cycle.
   assign load_en  = !out_valid || out_ready;

   // Grant is a subset of in_valid, so any in_ready bit is an input transfer.
   assign in_ready = rst ? '0 : (grant & {N_CH{load_en}});
   assign in_xfer  = |in_ready;

   assign sel_data = in_data[grant_idx*WIDTH +: WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f         <= '0;
         selector  <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (in_xfer) begin
         f         <= sel_data;
         selector  <= grant_idx;
         out_valid <= 1'b1;
         // The channel just served drops to lowest priority.
         ptr       <= grant_idx + sel_t'(1);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tdm_multiplexer.sv
// Purpose : directed self-checking bench for tdm_multiplexer (WIDTH=1).
// Latency : n/a.
// Backpres: exercised through out_ready stalls.
module tb_tdm_multiplexer;
   import tdm_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in_data = '0;
   logic [3:0] in_valid = '0;
   logic [3:0] in_ready;
   logic [0:0] f;
   logic [1:0] selector;
   logic       out_valid;
   logic       out_ready = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tdm_multiplexer #(.WIDTH(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .f         (f),
      .selector  (selector),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] pat [4];
   int         sent [4];
   int         recv [4];
   logic [15:0] ordy;
   logic [3:0] rdy_s;
   logic       ov_s;
   logic [1:0] sel_s;
   logic       f_s;
   logic       done;

   initial begin
      // ---------------- reset state ----------------
      in_valid  = 4'b1111;
      in_data   = 4'b1010;
      out_ready = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_f", f, 0);
      chk("rst_selector", selector, 0);
      chk("rst_in_ready", in_ready, 4'b0000);
      tick;
      chk("rst_hold_valid", out_valid, 0);

      // ---------------- full rotation ----------------
      rst = 1'b0;
      #1;
      chk("rot_first_rdy", in_ready, 4'b0001);
      for (int i = 0; i < 8; i++) begin
         tick;
         chk($sformatf("rot_valid_%0d", i), out_valid, 1);
         chk($sformatf("rot_sel_%0d", i), selector, i % 4);
         chk($sformatf("rot_f_%0d", i), f, i % 2);
         if (i < 7) chk($sformatf("rot_rdy_%0d", i), in_ready, 32'(1) << ((i + 1) % 4));
      end

      // ---------------- backpressure (ptr=0, ch2/ch3 valid) ----------------
      in_valid = 4'b1100;
      in_data  = 4'b1100;
      #1;
      chk("bp_pre_rdy", in_ready, 4'b0100);
      tick;
      chk("bp_load_sel", selector, 2);
      chk("bp_load_f", f, 1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp_rdy_%0d", i), in_ready, 4'b0000);
         tick;
         chk($sformatf("bp_valid_%0d", i), out_valid, 1);
         chk($sformatf("bp_sel_%0d", i), selector, 2);
         chk($sformatf("bp_f_%0d", i), f, 1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", in_ready, 4'b1000);
      tick;
      chk("bp_release_sel", selector, 3);
      chk("bp_release_f", f, 1);
      chk("bp_release_valid", out_valid, 1);

      // ---------------- idle ----------------
      in_valid = 4'b0000;
      #1;
      chk("idle_rdy", in_ready, 4'b0000);
      tick;
      chk("idle_valid", out_valid, 0);
      chk("idle_sel_kept", selector, 3);
      chk("idle_f_kept", f, 1);
      tick;
      chk("idle_valid2", out_valid, 0);

      // ---------------- sparse requests, ptr=0 ----------------
      in_valid = 4'b1001;
      in_data  = 4'b1000;
      tick;
      chk("sp_sel0", selector, 0);
      chk("sp_f0", f, 0);
      tick;
      chk("sp_sel1", selector, 3);
      chk("sp_f1", f, 1);
      tick;
      chk("sp_sel2_wrap", selector, 0);
      chk("sp_f2", f, 0);

      // ---------------- reset mid-stream ----------------
      in_valid = 4'b1111;
      in_data  = 4'b1010;
      tick;
      chk("mid_pre_sel", selector, 1);
      chk("mid_pre_f", f, 1);
      chk("mid_pre_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_f", f, 0);
      chk("mid_rst_sel", selector, 0);
      chk("mid_rst_rdy", in_ready, 4'b0000);
      tick;
      rst = 1'b0;
      #1;
      chk("mid_post_rdy", in_ready, 4'b0001);
      tick;
      chk("mid_post_sel", selector, 0);
      chk("mid_post_valid", out_valid, 1);

      // ---------------- end-to-end through a demux model ----------------
      rst = 1'b1;
      tick;
      rst = 1'b0;
      pat[0] = 4'b1011;
      pat[1] = 4'b0110;
      pat[2] = 4'b1100;
      pat[3] = 4'b0001;
      ordy   = 16'b1011_0111_1101_1110;
      for (int c = 0; c < 4; c++) begin
         sent[c] = 0;
         recv[c] = 0;
      end
      done = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            in_valid[c] = (sent[c] < 4);
            in_data[c]  = (sent[c] < 4) ? pat[c][sent[c]] : 1'b0;
         end
         out_ready = ordy[cyc % 16];
         #1;
         rdy_s = in_ready;
         ov_s  = out_valid && out_ready;
         sel_s = selector;
         f_s   = f[0];
         tick;
         if (ov_s) begin
            if (recv[sel_s] < 4) begin
               chk($sformatf("e2e_ch%0d_w%0d", sel_s, recv[sel_s]), f_s, pat[sel_s][recv[sel_s]]);
            end else begin
               chk($sformatf("e2e_extra_ch%0d", sel_s), recv[sel_s], 3);
            end
            recv[sel_s]++;
         end
         for (int c = 0; c < 4; c++) if (rdy_s[c]) sent[c]++;
         done = (recv[0] >= 4) && (recv[1] >= 4) && (recv[2] >= 4) && (recv[3] >= 4);
      end
      for (int c = 0; c < 4; c++) chk($sformatf("e2e_count_ch%0d", c), recv[c], 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
